reset_req_arb: RTL and testbench
================================

Name: reset_req_arb

Overview:
- Arbitrates reset requests from four sources (front-panel button, BMC register, watchdog, host) and sequences exactly one request at a time into the downstream reset request inputs: por_req_n, resetfull_req_n, hreset_req_n and sreset_req_n.
- Each request is pulsed for a fixed hold time, then completion is tracked on RESETSTATz. The requester gets an ack on completion or an err on timeout.
- Sits between the request sources and the reset request state machine.

Parameters:
- HOLD_CYCLES, 16, cycles the selected *_req_n is held low (1..2^24-1).
- TIMEOUT_CYCLES, 24'hFFFFFF, maximum cycles spent in each completion-wait state.
- GAP_CYCLES, 1024, lockout cycles after each completed or failed sequence before the next arbitration.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- src_req  in  4  level request per source; bit i = source i
- src_type  in  8  2 bits per source, [2i+1:2i]: 0 soft, 1 hard, 2 full, 3 POR
- src_ack  out  4  one-cycle pulse to the served source on successful completion
- src_err  out  4  one-cycle pulse to the served source on timeout
- cs_resetstat_n  in  1  RESETSTATz from the DSP, asynchronous to clk
- por_req_n  out  1  POR request, active low
- resetfull_req_n  out  1  full-reset request, active low
- hreset_req_n  out  1  hard-reset request, active low
- sreset_req_n  out  1  soft-reset request, active low
- busy  out  1  high in every state except IDLE
- last_src  out  2  index of the most recently granted source
- last_type  out  2  type of the most recently granted request

Behaviour:
- Reset values: all *_req_n = 1, src_ack = 0, src_err = 0, busy = 0, last_src = 0, last_type = 0, state = IDLE, counter = 0, arm mask = 4'hF. The synchroniser flops reset to 1.
- All outputs are registered. rst asserted at any point forces the reset values immediately, aborting any sequence. No ack or err is issued for an aborted sequence.
- cs_resetstat_n passes through a 2-flop synchroniser (rs_s) before use.
- Arm mask: a source is eligible only when src_req[i] & arm[i].
  - arm[i] clears when source i is granted.
  - arm[i] sets in any cycle where src_req[i] = 0.
  - A held request is therefore served once and must drop before it is served again.
- Arbitration, in IDLE only: the eligible request with the highest type wins. Ties go to the lowest index. Requests arriving in any other state wait; they are not queued beyond the level itself.
- State machine:
  - IDLE:
    - If any source is eligible, latch the winner into last_src/last_type, drive that type's *_req_n low, clear the counter, go to ASSERT.
    - The *_req_n goes low on the edge after the first cycle src_req is sampled high.
  - ASSERT:
    - Hold the selected *_req_n low for exactly HOLD_CYCLES cycles, then drive it high and go to WAIT_LOW. The counter is cleared on entry to each state.
    - Only one *_req_n is ever low at a time.
  - WAIT_LOW:
    - rs_s = 0 -> WAIT_HIGH.
    - The counter reaching TIMEOUT_CYCLES -> pulse src_err[last_src], go to GAP.
  - WAIT_HIGH:
    - rs_s = 1 -> pulse src_ack[last_src], go to GAP.
    - Timeout -> pulse src_err[last_src], go to GAP.
  - GAP: count GAP_CYCLES, then go to IDLE. busy drops on IDLE entry.
- Counter: 24 bits. Compares use >= (counter reaches limit). It never wraps, because the state changes at the limit.
- Simultaneous events:
  - If an src_req falls on the grant edge, the grant still proceeds.
  - If the served source drops its request mid-sequence, the sequence still completes and ack/err is still issued.
  - If rs_s = 0 is already present in ASSERT, it has no effect; WAIT_LOW samples it on its first cycle.
- No combinational paths from inputs to outputs.

Test Plan (bench: HOLD_CYCLES = 4, TIMEOUT_CYCLES = 100, GAP_CYCLES = 8):
1. Single request:
   - Stimulus: src_req = 4'b0010, src_type = 8'h04; rs_s driven low 10 cycles after hreset_req_n rises, high 20 cycles later.
   - Response: hreset_req_n low for exactly 4 cycles; src_ack = 4'b0010 for 1 cycle; busy high until 8 cycles after the ack; last_src = 1, last_type = 1.
2. Priority:
   - Stimulus: in the same cycle, src_req = 4'b1011 with types src0 = soft, src1 = full, src3 = POR.
   - Response: por_req_n pulses first. Then resetfull_req_n (src1). Then sreset_req_n (src0). Grants are served sequentially with no overlap.
3. Tie-break and arm:
   - Stimulus: src0 and src2 both hard, held high throughout.
   - Response: src0 is served, then src2. Neither is served again until its req drops for at least 1 cycle.
4. Timeout:
   - Stimulus: src_req[3] = soft; rs_s never goes low.
   - Response: src_err = 4'b1000 pulses 100 cycles after sreset_req_n releases; src_ack stays 0; busy returns to 0 after a further 8 cycles.
5. Reset mid-operation:
   - Stimulus: assert rst during ASSERT with por_req_n low.
   - Response: por_req_n = 1 asynchronously, busy = 0, no ack/err. After rst releases with src_req still high, the request is re-served because the arm mask is reset to 4'hF.
6. Lockout:
   - Stimulus: a new request arrives during GAP.
   - Response: the first *_req_n falls exactly 1 cycle after IDLE is re-entered, not earlier.

Source files
------------

// File: rtl/reset_req_arb.sv
// reset_req_arb
//   Arbitrates reset requests from four sources (front-panel button, BMC
//   register, watchdog, host) and sequences one request at a time onto the
//   active-low reset request lines. The selected line is held low for
//   HOLD_CYCLES, then completion is tracked on the synchronised RESETSTATz.
//   The served source gets a one-cycle ack on completion or err on timeout.
//   A GAP_CYCLES lockout follows every finished sequence.
//
// Ports
//   clk              system clock
//   rst              asynchronous active-high reset
//   src_req[3:0]     level request per source
//   src_type[7:0]    2 bits per source: 0 soft, 1 hard, 2 full, 3 POR
//   src_ack[3:0]     completion pulse to the served source
//   src_err[3:0]     timeout pulse to the served source
//   cs_resetstat_n   RESETSTATz from the DSP (asynchronous to clk)
//   por_req_n        POR request, active low
//   resetfull_req_n  full-reset request, active low
//   hreset_req_n     hard-reset request, active low
//   sreset_req_n     soft-reset request, active low
//   busy             high whenever the sequencer is not idle
//   last_src         index of the most recently granted source
//   last_type        type of the most recently granted request
module reset_req_arb #(
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 24'hFFFFFF,
    parameter int unsigned GAP_CYCLES     = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] src_req,
    input  logic [7:0] src_type,
    output logic [3:0] src_ack,
    output logic [3:0] src_err,
    input  logic       cs_resetstat_n,
    output logic       por_req_n,
    output logic       resetfull_req_n,
    output logic       hreset_req_n,
    output logic       sreset_req_n,
    output logic       busy,
    output logic [1:0] last_src,
    output logic [1:0] last_type
);

    // The counter starts at 0 on state entry, so terminating when it reaches
    // N-1 makes each timed state last exactly N cycles.
    function automatic logic [23:0] last_count(input int unsigned n);
        return (n == 0) ? 24'd0 : 24'(n - 1);
    endfunction

    localparam logic [23:0] HOLD_LIM    = last_count(HOLD_CYCLES);
    localparam logic [23:0] TIMEOUT_LIM = last_count(TIMEOUT_CYCLES);
    localparam logic [23:0] GAP_LIM     = last_count(GAP_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        ASSERT,
        WAIT_LOW,
        WAIT_HIGH,
        GAP
    } state_t;

    state_t      state;
    logic [23:0] cnt;
    logic [3:0]  arm;
    logic        rs_meta;
    logic        rs_s;

    logic [3:0]  eligible;
    logic        win_valid;
    logic [1:0]  win_idx;
    logic [1:0]  win_type;
    logic        grant;
    logic [3:0]  grant_mask;

    // Highest type wins; strict '>' keeps the lowest index on ties.
    always_comb begin
        eligible  = src_req & arm;
        win_valid = 1'b0;
        win_idx   = '0;
        win_type  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (eligible[i] && (!win_valid || (src_type[2*i +: 2] > win_type))) begin
                win_valid = 1'b1;
                win_idx   = 2'(i);
                win_type  = src_type[2*i +: 2];
            end
        end
        grant      = (state == IDLE) && win_valid;
        grant_mask = grant ? (4'b0001 << win_idx) : 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            arm             <= '1;
            rs_meta         <= 1'b1;
            rs_s            <= 1'b1;
            src_ack         <= '0;
            src_err         <= '0;
            por_req_n       <= 1'b1;
            resetfull_req_n <= 1'b1;
            hreset_req_n    <= 1'b1;
            sreset_req_n    <= 1'b1;
            busy            <= 1'b0;
            last_src        <= '0;
            last_type       <= '0;
        end else begin
            rs_meta <= cs_resetstat_n;
            rs_s    <= rs_meta;
            src_ack <= '0;
            src_err <= '0;
            // A granted source is disarmed until it drops its request.
            arm     <= (arm & ~grant_mask) | ~src_req;

            case (state)
                IDLE: begin
                    if (grant) begin
                        last_src  <= win_idx;
                        last_type <= win_type;
                        case (win_type)
                            2'd0:    sreset_req_n    <= 1'b0;
                            2'd1:    hreset_req_n    <= 1'b0;
                            2'd2:    resetfull_req_n <= 1'b0;
                            default: por_req_n       <= 1'b0;
                        endcase
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ASSERT;
                    end
                end

                ASSERT: begin
                    if (cnt >= HOLD_LIM) begin
                        por_req_n       <= 1'b1;
                        resetfull_req_n <= 1'b1;
                        hreset_req_n    <= 1'b1;
                        sreset_req_n    <= 1'b1;
                        cnt             <= '0;
                        state           <= WAIT_LOW;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end

                WAIT_LOW: begin
                    if (!rs_s) begin
                        cnt   <= '0;
                        state <= WAIT_HIGH;
                    end else if (cnt >= TIMEOUT_LIM) begin
                        src_err <= 4'b0001 << last_src;
                        cnt     <= '0;
                        state   <= GAP;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end

                WAIT_HIGH: begin
                    if (rs_s) begin
                        src_ack <= 4'b0001 << last_src;
                        cnt     <= '0;
                        state   <= GAP;
                    end else if (cnt >= TIMEOUT_LIM) begin
                        src_err <= 4'b0001 << last_src;
                        cnt     <= '0;
                        state   <= GAP;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end

                GAP: begin
                    if (cnt >= GAP_LIM) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end

                default: begin
                    cnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_req_arb.sv
// tb_reset_req_arb
//   Directed bench for reset_req_arb with HOLD_CYCLES=4, TIMEOUT_CYCLES=100,
//   GAP_CYCLES=8. Request lines are viewed as the vector
//   {por_req_n, resetfull_req_n, hreset_req_n, sreset_req_n}.
module tb_reset_req_arb;

    localparam int HOLD = 4;
    localparam int TMO  = 100;
    localparam int GAPC = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src_req;
    logic [7:0] src_type;
    logic [3:0] src_ack;
    logic [3:0] src_err;
    logic       cs_resetstat_n;
    logic       por_req_n;
    logic       resetfull_req_n;
    logic       hreset_req_n;
    logic       sreset_req_n;
    logic       busy;
    logic [1:0] last_src;
    logic [1:0] last_type;
    logic [3:0] pat;

    int n_checks = 0;
    int n_pass   = 0;

    reset_req_arb #(
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES    (GAPC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .src_req        (src_req),
        .src_type       (src_type),
        .src_ack        (src_ack),
        .src_err        (src_err),
        .cs_resetstat_n (cs_resetstat_n),
        .por_req_n      (por_req_n),
        .resetfull_req_n(resetfull_req_n),
        .hreset_req_n   (hreset_req_n),
        .sreset_req_n   (sreset_req_n),
        .busy           (busy),
        .last_src       (last_src),
        .last_type      (last_type)
    );

    assign pat = {por_req_n, resetfull_req_n, hreset_req_n, sreset_req_n};

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for any request line to fall and check which one and the grant info.
    task automatic wait_grant(input string tag, input logic [3:0] exp_pat,
                              input logic [1:0] exp_src, input logic [1:0] exp_type);
        bit seen = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (pat != 4'hF) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_pat"}, 32'(pat), 32'(exp_pat));
        check({tag, "_src"}, 32'(last_src), 32'(exp_src));
        check({tag, "_type"}, 32'(last_type), 32'(exp_type));
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    // Starting on the grant sample: measure hold, run a RESETSTATz handshake,
    // then expect the ack pulse.
    task automatic finish_to_ack(input string tag, input logic [3:0] exp_pat,
                                 input int src, input int lo_dly, input int hi_dly);
        int  n    = 1;
        bit  seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (pat == exp_pat) n++;
            else break;
        end
        check({tag, "_hold"}, 32'(n), 32'(HOLD));
        check({tag, "_released"}, 32'(pat), 32'hF);
        repeat (lo_dly) tick();
        cs_resetstat_n = 1'b0;
        repeat (hi_dly) tick();
        cs_resetstat_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if ((src_ack | src_err) != 4'b0) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_ack_seen"}, 32'(seen), 32'd1);
        check({tag, "_ack"}, 32'(src_ack), 32'(4'b0001 << src));
        check({tag, "_no_err"}, 32'(src_err), 32'd0);
    endtask

    // Starting on the ack/err sample: pulse is one cycle, GAP lasts GAPC
    // cycles and no request line moves during it.
    task automatic wait_idle(input string tag);
        int n     = 0;
        int early = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n++;
            if (i == 0) check({tag, "_pulse_len"}, 32'(src_ack | src_err), 32'd0);
            if (pat != 4'hF) early++;
            if (!busy) break;
        end
        check({tag, "_gap_len"}, 32'(n), 32'(GAPC));
        check({tag, "_gap_quiet"}, 32'(early), 32'd0);
    endtask

    initial begin
        int  n;
        bit  acked;
        int  active;

        rst            = 1'b1;
        src_req        = 4'b0;
        src_type       = 8'h00;
        cs_resetstat_n = 1'b1;
        #1;
        check("rst_pat", 32'(pat), 32'hF);
        check("rst_ack", 32'(src_ack), 32'd0);
        check("rst_err", 32'(src_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_last", 32'({last_src, last_type}), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // 1. single hard request from src1; request dropped mid-sequence
        src_req  = 4'b0010;
        src_type = 8'h04;
        wait_grant("t1", 4'b1101, 2'd1, 2'd1);
        src_req = 4'b0000;
        finish_to_ack("t1", 4'b1101, 1, 10, 20);
        wait_idle("t1");

        // 2. priority: POR(src3) > full(src1) > soft(src0)
        src_type = 8'hC8;
        src_req  = 4'b1011;
        wait_grant("t2a", 4'b0111, 2'd3, 2'd3);
        finish_to_ack("t2a", 4'b0111, 3, 2, 5);
        wait_idle("t2a");
        wait_grant("t2b", 4'b1011, 2'd1, 2'd2);
        finish_to_ack("t2b", 4'b1011, 1, 2, 5);
        wait_idle("t2b");
        wait_grant("t2c", 4'b1110, 2'd0, 2'd0);
        finish_to_ack("t2c", 4'b1110, 0, 2, 5);
        wait_idle("t2c");
        src_req = 4'b0000;
        repeat (2) tick();

        // 3. tie-break and arm mask with src0/src2 both hard and held
        src_type = 8'h11;
        src_req  = 4'b0101;
        wait_grant("t3a", 4'b1101, 2'd0, 2'd1);
        finish_to_ack("t3a", 4'b1101, 0, 2, 5);
        wait_idle("t3a");
        wait_grant("t3b", 4'b1101, 2'd2, 2'd1);
        finish_to_ack("t3b", 4'b1101, 2, 2, 5);
        wait_idle("t3b");
        active = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy || pat != 4'hF) active++;
        end
        check("t3_held_not_reserved", 32'(active), 32'd0);
        src_req = 4'b0100;
        tick();
        src_req = 4'b0101;
        wait_grant("t3c", 4'b1101, 2'd0, 2'd1);
        finish_to_ack("t3c", 4'b1101, 0, 2, 5);
        wait_idle("t3c");
        src_req = 4'b0000;
        repeat (2) tick();

        // 4. timeout: soft request from src3, RESETSTATz never falls
        src_type = 8'h00;
        src_req  = 4'b1000;
        wait_grant("t4", 4'b1110, 2'd3, 2'd0);
        n = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (pat == 4'b1110) n++;
            else break;
        end
        check("t4_hold", 32'(n), 32'(HOLD));
        n     = 0;
        acked = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            n++;
            if (src_ack != 4'b0) acked = 1;
            if (src_err != 4'b0) break;
        end
        check("t4_err_delay", 32'(n), 32'(TMO));
        check("t4_err", 32'(src_err), 32'h8);
        check("t4_no_ack", 32'(acked), 32'd0);
        wait_idle("t4");
        src_req = 4'b0000;
        repeat (2) tick();

        // 5. reset during ASSERT of a POR request
        src_type = 8'hC0;
        src_req  = 4'b1000;
        wait_grant("t5a", 4'b0111, 2'd3, 2'd3);
        tick();
        rst = 1'b1;
        #1;
        check("t5_por_async", 32'(por_req_n), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ack_err", 32'({src_ack, src_err}), 32'd0);
        check("t5_last_src", 32'(last_src), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        wait_grant("t5b", 4'b0111, 2'd3, 2'd3);
        finish_to_ack("t5b", 4'b0111, 3, 2, 5);
        wait_idle("t5b");
        src_req = 4'b0000;
        repeat (2) tick();

        // 6. lockout: a new request arriving in GAP waits for IDLE
        src_type = 8'h00;
        src_req  = 4'b0001;
        wait_grant("t6a", 4'b1110, 2'd0, 2'd0);
        finish_to_ack("t6a", 4'b1110, 0, 2, 5);
        src_type = 8'h04;
        src_req  = 4'b0011;
        wait_idle("t6a");
        check("t6_idle_pat", 32'(pat), 32'hF);
        tick();
        check("t6_grant_pat", 32'(pat), 32'hD);
        check("t6_grant_src", 32'(last_src), 32'd1);
        finish_to_ack("t6b", 4'b1101, 1, 2, 5);
        wait_idle("t6b");
        src_req = 4'b0000;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
